// File: rtl/aqp_ovl_wr_arbiter_pkg.sv
// Shared definitions for the overlay write arbiter: target selects, FSM states
// and the request bundle carried from the granted requester to the output registers.
package aqp_ovl_wr_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 11;

    localparam logic [1:0] SEL_TEXT = 2'd0;
    localparam logic [1:0] SEL_FONT = 2'd1;
    localparam logic [1:0] SEL_PAL  = 2'd2;
    localparam logic [1:0] SEL_RSVD = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [1:0]        sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/aqp_ovl_wr_arbiter_rr_arb2.sv
// Two-way round-robin grant. Grants are combinational from the requests; the
// last-served flag only moves when a grant is actually given.
module aqp_rr_arb2
    import aqp_ovl_wr_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic hold,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic last_b;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!hold) begin
            if (req_a && (!req_b || last_b)) begin
                gnt_a = 1'b1;
            end else if (req_b) begin
                gnt_b = 1'b1;
            end
        end
    end

    // Starting as "B served last" lets A win the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_b <= 1'b1;
        end else if (gnt_a) begin
            last_b <= 1'b0;
        end else if (gnt_b) begin
            last_b <= 1'b1;
        end
    end

endmodule

// File: rtl/aqp_ovl_wr_arbiter.sv
// Overlay memory write arbiter: shares the text/font/palette write ports between
// two requesters and runs a text-RAM clear sequencer.
module aqp_ovl_wr_arbiter
    import aqp_ovl_wr_arbiter_pkg::*;
#(
    parameter int TEXT_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [1:0]  a_sel,
    input  logic [10:0] a_addr,
    input  logic [15:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [1:0]  b_sel,
    input  logic [10:0] b_addr,
    input  logic [15:0] b_data,
    input  logic        clr_start,
    input  logic [15:0] clr_data,
    output logic        clr_busy,
    output logic        err_sel,
    output logic [9:0]  ovl_text_addr,
    output logic [15:0] ovl_text_wrdata,
    output logic        ovl_text_wr,
    output logic [10:0] ovl_font_addr,
    output logic [7:0]  ovl_font_wrdata,
    output logic        ovl_font_wr,
    output logic [3:0]  ovl_palette_addr,
    output logic [15:0] ovl_palette_wrdata,
    output logic        ovl_palette_wr
);

    localparam logic [9:0] LAST_IDX = 10'(TEXT_DEPTH - 1);

    arb_state_e  state;
    logic [9:0]  clr_cnt;
    logic [15:0] clr_fill;
    logic        hold;
    logic        gnt_a;
    logic        gnt_b;
    logic        vld_p0;
    wr_req_t     req_p0;

    // A clear request in IDLE pre-empts any write in the same cycle.
    assign hold = (state != ST_IDLE) || clr_start;

    aqp_rr_arb2 u_rr (
        .clk   (clk),
        .reset (reset),
        .hold  (hold),
        .req_a (a_valid),
        .req_b (b_valid),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    assign a_ready  = gnt_a;
    assign b_ready  = gnt_b;
    assign clr_busy = (state == ST_CLEAR);

    // Stage p0: the granted request, selected from whichever side won.
    assign vld_p0 = gnt_a || gnt_b;
    assign req_p0 = gnt_b ? '{sel: b_sel, addr: b_addr, data: b_data}
                          : '{sel: a_sel, addr: a_addr, data: a_data};

    // Stage p1: registered strobes, addresses and data on the overlay ports.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_IDLE;
            clr_cnt            <= '0;
            clr_fill           <= '0;
            err_sel            <= 1'b0;
            ovl_text_wr        <= 1'b0;
            ovl_text_addr      <= '0;
            ovl_text_wrdata    <= '0;
            ovl_font_wr        <= 1'b0;
            ovl_font_addr      <= '0;
            ovl_font_wrdata    <= '0;
            ovl_palette_wr     <= 1'b0;
            ovl_palette_addr   <= '0;
            ovl_palette_wrdata <= '0;
        end else begin
            err_sel        <= 1'b0;
            ovl_text_wr    <= 1'b0;
            ovl_font_wr    <= 1'b0;
            ovl_palette_wr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clr_start) begin
                        state    <= ST_CLEAR;
                        clr_fill <= clr_data;
                        clr_cnt  <= '0;
                    end else if (vld_p0) begin
                        case (req_p0.sel)
                            SEL_TEXT: begin
                                ovl_text_wr     <= 1'b1;
                                ovl_text_addr   <= req_p0.addr[9:0];
                                ovl_text_wrdata <= req_p0.data;
                            end
                            SEL_FONT: begin
                                ovl_font_wr     <= 1'b1;
                                ovl_font_addr   <= req_p0.addr;
                                ovl_font_wrdata <= req_p0.data[7:0];
                            end
                            SEL_PAL: begin
                                ovl_palette_wr     <= 1'b1;
                                ovl_palette_addr   <= req_p0.addr[3:0];
                                ovl_palette_wrdata <= req_p0.data;
                            end
                            default: err_sel <= 1'b1;
                        endcase
                    end
                end
                ST_CLEAR: begin
                    ovl_text_wr     <= 1'b1;
                    ovl_text_addr   <= clr_cnt;
                    ovl_text_wrdata <= clr_fill;
                    clr_cnt         <= clr_cnt + 10'd1;
                    if (clr_cnt == LAST_IDX) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aqp_ovl_wr_arbiter.sv
// Directed and random bench for aqp_ovl_wr_arbiter against a cycle-level reference model.
module tb_aqp_ovl_wr_arbiter;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [1:0]  a_sel, b_sel;
    logic [10:0] a_addr, b_addr;
    logic [15:0] a_data, b_data;
    logic        clr_start;
    logic [15:0] clr_data;
    logic        clr_busy, err_sel;
    logic [9:0]  ovl_text_addr;
    logic [15:0] ovl_text_wrdata;
    logic        ovl_text_wr;
    logic [10:0] ovl_font_addr;
    logic [7:0]  ovl_font_wrdata;
    logic        ovl_font_wr;
    logic [3:0]  ovl_palette_addr;
    logic [15:0] ovl_palette_wrdata;
    logic        ovl_palette_wr;

    always #5 clk = ~clk;

    aqp_ovl_wr_arbiter #(.TEXT_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_sel(a_sel), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_sel(b_sel), .b_addr(b_addr), .b_data(b_data),
        .clr_start(clr_start), .clr_data(clr_data), .clr_busy(clr_busy), .err_sel(err_sel),
        .ovl_text_addr(ovl_text_addr), .ovl_text_wrdata(ovl_text_wrdata), .ovl_text_wr(ovl_text_wr),
        .ovl_font_addr(ovl_font_addr), .ovl_font_wrdata(ovl_font_wrdata), .ovl_font_wr(ovl_font_wr),
        .ovl_palette_addr(ovl_palette_addr), .ovl_palette_wrdata(ovl_palette_wrdata),
        .ovl_palette_wr(ovl_palette_wr)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: clear progress, fill value, who was served last, expected port image.
    bit          m_clear;
    int          m_idx;
    logic [15:0] m_fill;
    bit          m_last_b;
    logic        e_twr, e_fwr, e_pwr, e_err;
    logic [9:0]  e_taddr;
    logic [15:0] e_tdata;
    logic [10:0] e_faddr;
    logic [7:0]  e_fdata;
    logic [3:0]  e_paddr;
    logic [15:0] e_pdata;
    bit          g_a, g_b;
    int          text_writes;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clear = 0; m_idx = 0; m_fill = '0; m_last_b = 1;
        e_twr = 0; e_fwr = 0; e_pwr = 0; e_err = 0;
        e_taddr = '0; e_tdata = '0; e_faddr = '0; e_fdata = '0; e_paddr = '0; e_pdata = '0;
    endtask

    task automatic apply_write(input logic [1:0] sel, input logic [10:0] addr, input logic [15:0] data);
        case (sel)
            2'd0: begin e_twr = 1; e_taddr = addr[9:0]; e_tdata = data; end
            2'd1: begin e_fwr = 1; e_faddr = addr; e_fdata = data[7:0]; end
            2'd2: begin e_pwr = 1; e_paddr = addr[3:0]; e_pdata = data; end
            default: e_err = 1;
        endcase
    endtask

    // One clock: check readies against the model, predict the next port image, check it after the edge.
    task automatic tick();
        bit ea, eb;
        #2;
        ea = 0; eb = 0;
        if (!reset && !m_clear && !clr_start) begin
            if (a_valid && (!b_valid || m_last_b)) ea = 1;
            else if (b_valid) eb = 1;
        end
        if (!reset) begin
            chk("a_ready", 32'(a_ready), 32'(ea));
            chk("b_ready", 32'(b_ready), 32'(eb));
        end
        g_a = ea; g_b = eb;
        e_twr = 0; e_fwr = 0; e_pwr = 0; e_err = 0;
        if (reset) begin
            model_reset();
        end else if (m_clear) begin
            e_twr = 1; e_taddr = 10'(m_idx); e_tdata = m_fill;
            m_idx++;
            if (m_idx == DEPTH) m_clear = 0;
        end else if (clr_start) begin
            m_clear = 1; m_idx = 0; m_fill = clr_data;
        end else if (ea) begin
            apply_write(a_sel, a_addr, a_data); m_last_b = 0;
        end else if (eb) begin
            apply_write(b_sel, b_addr, b_data); m_last_b = 1;
        end
        @(posedge clk);
        #1;
        if (ovl_text_wr === 1'b1) text_writes++;
        chk("text_wr", 32'(ovl_text_wr), 32'(e_twr));
        chk("font_wr", 32'(ovl_font_wr), 32'(e_fwr));
        chk("pal_wr", 32'(ovl_palette_wr), 32'(e_pwr));
        chk("err_sel", 32'(err_sel), 32'(e_err));
        chk("clr_busy", 32'(clr_busy), 32'(m_clear));
        chk("text_addr", 32'(ovl_text_addr), 32'(e_taddr));
        chk("text_data", 32'(ovl_text_wrdata), 32'(e_tdata));
        chk("font_addr", 32'(ovl_font_addr), 32'(e_faddr));
        chk("font_data", 32'(ovl_font_wrdata), 32'(e_fdata));
        chk("pal_addr", 32'(ovl_palette_addr), 32'(e_paddr));
        chk("pal_data", 32'(ovl_palette_wrdata), 32'(e_pdata));
    endtask

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; clr_start = 0; clr_data = '0;
        a_sel = '0; a_addr = '0; a_data = '0; b_sel = '0; b_addr = '0; b_data = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a_wait, b_wait;
        model_reset();
        idle_inputs();
        text_writes = 0;

        // Reset state
        reset = 1;
        @(posedge clk); #1;
        tick(); tick();
        reset = 0;
        tick();

        // Single A write to text
        a_valid = 1; a_sel = 2'd0; a_addr = 11'h123; a_data = 16'hBEEF;
        tick();
        chk("t1_a_ready", 32'(g_a), 32'd1);
        chk("t1_text_addr", 32'(ovl_text_addr), 32'h123);
        chk("t1_text_data", 32'(ovl_text_wrdata), 32'hBEEF);
        a_valid = 0;
        tick();

        // Alternating grants under continuous contention, A first after reset
        reset = 1; tick(); reset = 0;
        a_valid = 1; b_valid = 1;
        for (int i = 0; i < 4; i++) begin
            a_sel = 2'd2; a_addr = 11'(i); a_data = 16'(16'hA000 + i);
            b_sel = 2'd2; b_addr = 11'(8 + i); b_data = 16'(16'hB000 + i);
            tick();
            chk("t2_grant_a", 32'(a_ready_hist(g_a)), 32'((i % 2) == 0));
            chk("t2_pal_wr", 32'(ovl_palette_wr), 32'd1);
        end
        idle_inputs();

        // Font width truncation and reserved select
        b_valid = 1; b_sel = 2'd1; b_addr = 11'h7FF; b_data = 16'h01A5;
        tick();
        chk("t3_font_data", 32'(ovl_font_wrdata), 32'hA5);
        b_sel = 2'd3; b_addr = 11'h055; b_data = 16'h1234;
        tick();
        chk("t3_err_sel", 32'(err_sel), 32'd1);
        b_valid = 0;
        tick();

        // Full clear with A waiting; a second clr_start mid-clear is ignored
        a_valid = 1; a_sel = 2'd0; a_addr = 11'h3FF; a_data = 16'h5555;
        clr_start = 1; clr_data = 16'h0720;
        tick();
        clr_start = 0; clr_data = 16'hFFFF;
        text_writes = 0;
        for (int i = 0; i < DEPTH; i++) begin
            clr_start = (i == 300);
            tick();
        end
        clr_start = 0;
        chk("t4_clear_writes", 32'(text_writes), 32'(DEPTH));
        chk("t4_last_addr", 32'(ovl_text_addr), 32'(DEPTH - 1));
        tick();
        chk("t4_a_served", 32'(g_a), 32'd1);
        a_valid = 0;
        tick();

        // Reset partway through a clear, then a fresh clear restarts at 0
        clr_start = 1; clr_data = 16'h1111;
        tick();
        clr_start = 0;
        for (int i = 0; i < 500; i++) tick();
        reset = 1; tick(); reset = 0;
        chk("t5_busy_after_reset", 32'(clr_busy), 32'd0);
        clr_start = 1; clr_data = 16'h2222;
        tick();
        clr_start = 0;
        tick();
        chk("t5_restart_addr", 32'(ovl_text_addr), 32'd0);
        chk("t5_restart_data", 32'(ovl_text_wrdata), 32'h2222);
        while (m_clear) tick();
        tick();

        // Random traffic: requests held until accepted, fairness tracked per requester
        a_wait = 0; b_wait = 0;
        for (int i = 0; i < 600; i++) begin
            if (!a_valid && ($urandom % 3 == 0)) begin
                a_valid = 1; a_sel = 2'($urandom); a_addr = 11'($urandom); a_data = 16'($urandom);
            end
            if (!b_valid && ($urandom % 3 == 0)) begin
                b_valid = 1; b_sel = 2'($urandom); b_addr = 11'($urandom); b_data = 16'($urandom);
            end
            tick();
            if (a_valid && g_b) a_wait++;
            if (b_valid && g_a) b_wait++;
            if (g_a) begin a_valid = 0; a_wait = 0; end
            if (g_b) begin b_valid = 0; b_wait = 0; end
            chk("rnd_fair_a", 32'(a_wait <= 1), 32'd1);
            chk("rnd_fair_b", 32'(b_wait <= 1), 32'd1);
        end
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    function automatic bit a_ready_hist(input bit ga);
        return ga;
    endfunction

endmodule
